// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, pending scoreboard and bulk-clear sweep.
// Latency: reads are combinational (zero cycles); writes, allocs and clears land at the next rising edge.
// Backpressure: none; while the sweep runs, writes, allocs and clear requests are silently dropped.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [NREGS-1:0]     pending,
  input  logic                 clr_req,
  output logic                 clr_busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;

  // Per-register resolved write for this cycle (highest-index port wins).
  logic [NREGS-1:0]  wr_hit;
  logic [XLEN-1:0]   wr_val [NREGS];

  // Per-read-port address and selected value.
  logic [AW-1:0]     rd_idx [NRD];
  logic [XLEN-1:0]   rd_val [NRD];

  // Writes and allocs only count when idle and no clear is being requested.
  logic              accept;

  assign accept   = (state_q == S_IDLE) && !clr_req;
  assign clr_busy = (state_q == S_SWEEP);
  assign pending  = pending_q;

  // Resolve all write ports onto each register; later ports override earlier ones.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (accept && we[j] && (r != 0) && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Bulk-clear sequencer: next state and sweep pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_SWEEP;
          ptr_d   = AW'(1);
        end
      end
      S_SWEEP: begin
        // The pointer stops at the last register instead of wrapping.
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pending scoreboard: alloc beats a same-cycle write; a clear request wipes everything.
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_IDLE) begin
      if (clr_req) begin
        pending_d = '0;
      end else begin
        for (int r = 1; r < NREGS; r++) begin
          if (alloc_en && (alloc_addr == AW'(r))) begin
            pending_d[r] = 1'b1;
          end else if (wr_hit[r]) begin
            pending_d[r] = 1'b0;
          end
        end
      end
    end
    pending_d[0] = 1'b0;
  end

  // Read muxes: stored value, optionally overridden by this cycle's accepted write.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_idx[i] = rd_addr[i*AW +: AW];
      rd_val[i] = regs_q[rd_idx[i]];
      if ((BYPASS != 0) && wr_hit[rd_idx[i]]) begin
        rd_val[i] = wr_val[rd_idx[i]];
      end
      if (rd_idx[i] == '0) begin
        rd_val[i] = '0;
      end
      rd_data[i*XLEN +: XLEN] = rd_val[i];
    end
  end

  // Sequencer and scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  // Register storage: sweep clears the pointed register, otherwise apply resolved writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if ((state_q == S_SWEEP) && (ptr_q == AW'(r))) begin
          regs_q[r] <= '0;
        end else if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
// Expected values are queued as stimulus is driven and compared when outputs are sampled.
// Sampling happens 3 time units after the rising edge, inputs change 1 unit after it.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                clr_req;

  logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
  logic [NREGS-1:0]    pending_b1, pending_b0;
  logic                clr_busy_b1, clr_busy_b0;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  logic [31:0] mdl [NREGS];

  // Scoreboard queues (kind: 0 rd b1, 1 rd b0, 2 pending b1, 3 busy b1, 4 busy b0).
  string       q_tag  [$];
  int          q_kind [$];
  int          q_idx  [$];
  logic [31:0] q_exp  [$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b1),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending(pending_b1),
    .clr_req(clr_req), .clr_busy(clr_busy_b1)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b0),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending(pending_b0),
    .clr_req(clr_req), .clr_busy(clr_busy_b0)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] v);
    q_tag.push_back(tag);
    q_kind.push_back(kind);
    q_idx.push_back(idx);
    q_exp.push_back(v);
  endtask

  task automatic drain();
    string       tag;
    int          kind, idx;
    logic [31:0] exp, obs;
    while (q_exp.size() > 0) begin
      tag  = q_tag.pop_front();
      kind = q_kind.pop_front();
      idx  = q_idx.pop_front();
      exp  = q_exp.pop_front();
      case (kind)
        0:       obs = rd_data_b1[idx*XLEN +: XLEN];
        1:       obs = rd_data_b0[idx*XLEN +: XLEN];
        2:       obs = pending_b1;
        3:       obs = {31'b0, clr_busy_b1};
        default: obs = {31'b0, clr_busy_b0};
      endcase
      cmp(tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    we         = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    clr_req    = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d);
    we[p]                   = 1'b1;
    wr_addr[p*AW +: AW]     = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, a);
      set_rd(1, NREGS - 1 - a);
      push(tag, 0, 0, mdl[a]);
      push(tag, 0, 1, mdl[NREGS - 1 - a]);
      #1;
      drain();
    end
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) mdl[r] = '0;
    rst_n   = 1'b0;
    rd_addr = '0;
    idle_in();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset state.
    push("rst_pending", 2, 0, 32'h0);
    push("rst_busy", 3, 0, 32'h0);
    #2;
    drain();
    read_all("rst_read");
    step();

    // Two ports write r5 in one cycle: port 1 wins, bypassed on the BYPASS=1 instance.
    set_wr(0, 5, 32'hDEADBEEF);
    set_wr(1, 5, 32'h12345678);
    set_rd(0, 5);
    push("byp_same_cycle", 0, 0, 32'h12345678);
    push("nobyp_same_cycle", 1, 0, 32'h0);
    #2;
    drain();
    step();
    idle_in();
    mdl[5] = 32'h12345678;
    push("r5_stored_b1", 0, 0, 32'h12345678);
    push("r5_stored_b0", 1, 0, 32'h12345678);
    #2;
    drain();

    // BYPASS=0 returns the old value during the write cycle.
    step();
    set_wr(0, 7, 32'h11);
    step();
    idle_in();
    set_wr(0, 7, 32'h22);
    set_rd(0, 7);
    push("b0_old_value", 1, 0, 32'h11);
    push("b1_bypass_value", 0, 0, 32'h22);
    #2;
    drain();
    step();
    idle_in();
    mdl[7] = 32'h22;
    push("b0_new_value", 1, 0, 32'h22);
    #2;
    drain();

    // Register 0 ignores writes and allocs.
    step();
    set_wr(0, 0, 32'hFFFFFFFF);
    alloc_en   = 1'b1;
    alloc_addr = 5'd0;
    set_rd(0, 0);
    set_rd(1, 0);
    push("r0_bypass_p0", 0, 0, 32'h0);
    push("r0_bypass_p1", 0, 1, 32'h0);
    #2;
    drain();
    step();
    idle_in();
    push("r0_read", 0, 0, 32'h0);
    push("r0_pending", 2, 0, 32'h0);
    #2;
    drain();

    // Scoreboard set/clear/priority.
    step();
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    step();
    idle_in();
    push("alloc_r9", 2, 0, 32'h0000_0200);
    #2;
    drain();
    step();
    set_wr(1, 9, 32'h99);
    step();
    idle_in();
    set_rd(1, 9);
    push("write_clears_r9", 2, 0, 32'h0);
    push("r9_value", 0, 1, 32'h99);
    #2;
    drain();
    step();
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    set_wr(0, 9, 32'hAA);
    step();
    idle_in();
    push("alloc_beats_write", 2, 0, 32'h0000_0200);
    #2;
    drain();
    step();
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    step();
    idle_in();
    push("realloc_stays", 2, 0, 32'h0000_0200);
    #2;
    drain();
    step();
    set_wr(0, 9, 32'hBB);
    step();
    idle_in();
    push("final_clear_r9", 2, 0, 32'h0);
    #2;
    drain();

    // Fill r1..r31 with nonzero values.
    for (int a = 1; a < NREGS; a++) begin
      step();
      idle_in();
      set_wr(a % 2, a, 32'hA500_0000 | 32'(a));
      mdl[a] = 32'hA500_0000 | 32'(a);
    end
    step();
    idle_in();
    read_all("fill_read");

    // Clear request together with a write and an alloc: clear wins.
    step();
    clr_req = 1'b1;
    set_wr(0, 4, 32'hCAFE);
    alloc_en   = 1'b1;
    alloc_addr = 5'd10;
    step();
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      idle_in();
      if (k == 0) begin
        set_rd(0, 31);
        push("busy_start", 3, 0, 32'h1);
        push("clear_pending", 2, 0, 32'h0);
        push("sweep_read_r31", 0, 0, mdl[31]);
      end
      if (k == 5) clr_req = 1'b1;
      if (k == 20) begin
        set_wr(1, 3, 32'h3333);
        set_rd(1, 3);
        push("sweep_no_bypass", 0, 1, 32'h0);
      end
      #2;
      drain();
      if (!clr_busy_b1) break;
      busy_cnt++;
      step();
    end
    cmp("busy_length", 32'(busy_cnt), 32'd31);
    for (int r = 0; r < NREGS; r++) mdl[r] = '0;
    read_all("post_sweep_read");
    push("post_sweep_pending", 2, 0, 32'h0);
    #1;
    drain();

    // Reset mid-sweep drops clr_busy without a clock edge.
    step();
    idle_in();
    clr_req = 1'b1;
    step();
    idle_in();
    step();
    step();
    push("busy_mid", 3, 0, 32'h1);
    #2;
    drain();
    rst_n = 1'b0;
    #1;
    push("rst_abort_b1", 3, 0, 32'h0);
    push("rst_abort_b0", 4, 0, 32'h0);
    drain();
    #2;
    rst_n = 1'b1;
    step();
    push("after_rst_busy", 3, 0, 32'h0);
    push("after_rst_pending", 2, 0, 32'h0);
    #2;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
